reservation_station: RTL and testbench



---
 rtl/reservation_station.sv | 167 ++++++++++++++++
 tb/tb_reservation_station.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Out-of-order ALU issue queue: holds decoded ops, snoops ALU/LSB result buses,
// and issues the lowest-index ready entry as a registered one-cycle request.
module reservation_station #(
  parameter int RS_SIZE       = 8,
  parameter int RS_IDX_WIDTH  = 3,
  parameter int ROB_WIDTH     = 3,
  parameter int RS_TYPE_WIDTH = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     dec_rdy,
  input  logic [RS_TYPE_WIDTH-1:0] dec_type,
  input  logic [31:0]              dec_data_j,
  input  logic [31:0]              dec_data_k,
  input  logic                     dec_pending_j,
  input  logic                     dec_pending_k,
  input  logic [ROB_WIDTH-1:0]     dec_dependency_j,
  input  logic [ROB_WIDTH-1:0]     dec_dependency_k,
  input  logic [ROB_WIDTH-1:0]     dec_rob_id,
  input  logic [31:0]              dec_imm,
  output logic                     full,
  input  logic                     alu_cdb_valid,
  input  logic [ROB_WIDTH-1:0]     alu_cdb_rob_id,
  input  logic [31:0]              alu_cdb_value,
  input  logic                     lsb_cdb_valid,
  input  logic [ROB_WIDTH-1:0]     lsb_cdb_rob_id,
  input  logic [31:0]              lsb_cdb_value,
  output logic                     alu_en,
  output logic [RS_TYPE_WIDTH-1:0] alu_type,
  output logic [31:0]              alu_op1,
  output logic [31:0]              alu_op2,
  output logic [31:0]              alu_imm,
  output logic [ROB_WIDTH-1:0]     alu_rob_id
);

  typedef struct packed {
    logic [RS_TYPE_WIDTH-1:0] op_type;
    logic [31:0]              vj;
    logic [31:0]              vk;
    logic                     pj;
    logic                     pk;
    logic [ROB_WIDTH-1:0]     qj;
    logic [ROB_WIDTH-1:0]     qk;
    logic [ROB_WIDTH-1:0]     rob_id;
    logic [31:0]              imm;
  } rs_entry_t;

  rs_entry_t              ent [RS_SIZE];
  logic [RS_SIZE-1:0]     valid;

  rs_entry_t              new_ent;
  logic [RS_IDX_WIDTH-1:0] free_idx;
  logic                   has_free;
  logic [RS_IDX_WIDTH-1:0] issue_idx;
  logic                   has_issue;

  // Returns {still_pending, value}; the ALU bus wins if both buses match.
  function automatic logic [32:0] snoop(
    input logic                 pending,
    input logic [ROB_WIDTH-1:0] tag,
    input logic [31:0]          value,
    input logic                 a_valid,
    input logic [ROB_WIDTH-1:0] a_tag,
    input logic [31:0]          a_value,
    input logic                 l_valid,
    input logic [ROB_WIDTH-1:0] l_tag,
    input logic [31:0]          l_value
  );
    if (pending && a_valid && a_tag == tag)      return {1'b0, a_value};
    else if (pending && l_valid && l_tag == tag) return {1'b0, l_value};
    else                                         return {pending, value};
  endfunction

  assign full = &valid;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    new_ent         = '0;
    new_ent.op_type = dec_type;
    new_ent.qj      = dec_dependency_j;
    new_ent.qk      = dec_dependency_k;
    new_ent.rob_id  = dec_rob_id;
    new_ent.imm     = dec_imm;
    {new_ent.pj, new_ent.vj} = snoop(dec_pending_j, dec_dependency_j, dec_data_j,
                                     alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
                                     lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
    {new_ent.pk, new_ent.vk} = snoop(dec_pending_k, dec_dependency_k, dec_data_k,
                                     alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
                                     lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    free_idx  = '0;
    has_free  = 1'b0;
    issue_idx = '0;
    has_issue = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = RS_IDX_WIDTH'(i);
        has_free = 1'b1;
      end
      if (valid[i] && !ent[i].pj && !ent[i].pk) begin
        issue_idx = RS_IDX_WIDTH'(i);
        has_issue = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid      <= '0;
      alu_en     <= 1'b0;
      alu_type   <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_imm    <= '0;
      alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        valid  <= '0;
        alu_en <= 1'b0;
      end else begin
        alu_en <= has_issue;
        if (has_issue) begin
          valid[issue_idx] <= 1'b0;
          alu_type         <= ent[issue_idx].op_type;
          alu_op1          <= ent[issue_idx].vj;
          alu_op2          <= ent[issue_idx].vk;
          alu_imm          <= ent[issue_idx].imm;
          alu_rob_id       <= ent[issue_idx].rob_id;
        end
        // free_idx is never the issuing slot, so a freed slot is reused next cycle.
        if (dec_rdy && has_free) valid[free_idx] <= 1'b1;
      end
    end
  end

  // NOTE: entry payload is qualified by valid, so the storage array needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid[i]) begin
          if (ent[i].pj && alu_cdb_valid && alu_cdb_rob_id == ent[i].qj) begin
            ent[i].vj <= alu_cdb_value;
            ent[i].pj <= 1'b0;
          end else if (ent[i].pj && lsb_cdb_valid && lsb_cdb_rob_id == ent[i].qj) begin
            ent[i].vj <= lsb_cdb_value;
            ent[i].pj <= 1'b0;
          end
          if (ent[i].pk && alu_cdb_valid && alu_cdb_rob_id == ent[i].qk) begin
            ent[i].vk <= alu_cdb_value;
            ent[i].pk <= 1'b0;
          end else if (ent[i].pk && lsb_cdb_valid && lsb_cdb_rob_id == ent[i].qk) begin
            ent[i].vk <= lsb_cdb_value;
            ent[i].pk <= 1'b0;
          end
        end
      end
      if (dec_rdy && has_free) ent[free_idx] <= new_ent;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: insert, forwarding, wakeup, ordering,
// flush, stall and asynchronous reset, each with hand-computed expectations.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        dec_rdy;
  logic [5:0]  dec_type;
  logic [31:0] dec_data_j, dec_data_k;
  logic        dec_pending_j, dec_pending_k;
  logic [2:0]  dec_dependency_j, dec_dependency_k;
  logic [2:0]  dec_rob_id;
  logic [31:0] dec_imm;
  logic        full;
  logic        alu_cdb_valid;
  logic [2:0]  alu_cdb_rob_id;
  logic [31:0] alu_cdb_value;
  logic        lsb_cdb_valid;
  logic [2:0]  lsb_cdb_rob_id;
  logic [31:0] lsb_cdb_value;
  logic        alu_en;
  logic [5:0]  alu_type;
  logic [31:0] alu_op1, alu_op2, alu_imm;
  logic [2:0]  alu_rob_id;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush            (flush),
    .dec_rdy          (dec_rdy),
    .dec_type         (dec_type),
    .dec_data_j       (dec_data_j),
    .dec_data_k       (dec_data_k),
    .dec_pending_j    (dec_pending_j),
    .dec_pending_k    (dec_pending_k),
    .dec_dependency_j (dec_dependency_j),
    .dec_dependency_k (dec_dependency_k),
    .dec_rob_id       (dec_rob_id),
    .dec_imm          (dec_imm),
    .full             (full),
    .alu_cdb_valid    (alu_cdb_valid),
    .alu_cdb_rob_id   (alu_cdb_rob_id),
    .alu_cdb_value    (alu_cdb_value),
    .lsb_cdb_valid    (lsb_cdb_valid),
    .lsb_cdb_rob_id   (lsb_cdb_rob_id),
    .lsb_cdb_value    (lsb_cdb_value),
    .alu_en           (alu_en),
    .alu_type         (alu_type),
    .alu_op1          (alu_op1),
    .alu_op2          (alu_op2),
    .alu_imm          (alu_imm),
    .alu_rob_id       (alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dec_rdy       = 1'b0;
    dec_pending_j = 1'b0;
    dec_pending_k = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic insert(input logic [5:0] t, input logic [31:0] dj, input logic [31:0] dk,
                        input logic pj, input logic pk, input logic [2:0] qj,
                        input logic [2:0] qk, input logic [2:0] rob, input logic [31:0] imm);
    dec_rdy = 1'b1; dec_type = t; dec_data_j = dj; dec_data_k = dk;
    dec_pending_j = pj; dec_pending_k = pk; dec_dependency_j = qj; dec_dependency_k = qk;
    dec_rob_id = rob; dec_imm = imm;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; idle();
    dec_type = '0; dec_data_j = '0; dec_data_k = '0; dec_dependency_j = '0;
    dec_dependency_k = '0; dec_rob_id = '0; dec_imm = '0;
    alu_cdb_rob_id = '0; alu_cdb_value = '0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
    step(); step();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", alu_en); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++; if ({alu_type, alu_op1, alu_op2, alu_imm, alu_rob_id} !== '0) begin
      errors++; $display("FAIL reset_outputs got op1=%0h op2=%0h imm=%0h want 0", alu_op1, alu_op2, alu_imm);
    end
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_basic();
    insert(6'b000000, 32'd5, 32'd7, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 32'h1234);
    step(); idle();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL basic_same_edge got %0b want 0", alu_en); end
    step();
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL basic_en got %0b want 1", alu_en); end
    checks++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin
      errors++; $display("FAIL basic_ops got %0d/%0d want 5/7", alu_op1, alu_op2);
    end
    checks++; if (alu_rob_id !== 3'd2 || alu_imm !== 32'h1234 || alu_type !== 6'b0) begin
      errors++; $display("FAIL basic_tag got rob=%0d imm=%0h type=%0b want 2/1234/0", alu_rob_id, alu_imm, alu_type);
    end
    step();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL basic_one_pulse got %0b want 0", alu_en); end
  endtask

  task automatic test_wakeup();
    insert(6'b110101, 32'hFFFF, 32'd9, 1'b1, 1'b0, 3'd3, 3'd0, 3'd5, 32'h40);
    step(); idle();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_pending0 got %0b want 0", alu_en); end
    checks++; if (alu_op1 !== 32'd5) begin errors++; $display("FAIL wake_hold_op1 got %0h want 5", alu_op1); end
    step();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_pending1 got %0b want 0", alu_en); end
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 3'd3; alu_cdb_value = 32'h10;
    step(); idle();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_same_edge got %0b want 0", alu_en); end
    step();
    checks++; if (alu_en !== 1'b1 || alu_op1 !== 32'h10 || alu_op2 !== 32'd9) begin
      errors++; $display("FAIL wake_issue got en=%0b op1=%0h op2=%0h want 1/10/9", alu_en, alu_op1, alu_op2);
    end
    checks++; if (alu_rob_id !== 3'd5 || alu_type !== 6'b110101 || alu_imm !== 32'h40) begin
      errors++; $display("FAIL wake_fields got rob=%0d type=%0b imm=%0h want 5/110101/40", alu_rob_id, alu_type, alu_imm);
    end
    step();
  endtask

  task automatic test_forward();
    insert(6'b000010, 32'd1, 32'hDEAD, 1'b0, 1'b1, 3'd0, 3'd4, 3'd3, 32'h0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 3'd4; lsb_cdb_value = 32'hAB;
    step(); idle();
    step();
    checks++; if (alu_en !== 1'b1 || alu_op2 !== 32'hAB || alu_op1 !== 32'd1 || alu_rob_id !== 3'd3) begin
      errors++; $display("FAIL forward got en=%0b op1=%0h op2=%0h rob=%0d want 1/1/ab/3", alu_en, alu_op1, alu_op2, alu_rob_id);
    end
    step();
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < 8; i++) begin
      insert(6'b0, 32'd0, 32'(i), 1'b1, 1'b0, 3'd1, 3'd0, 3'(i), 32'd0);
      step();
      if (i == 6) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_seven got %0b want 0", full); end
      end
    end
    idle();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", full); end
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 3'd1; alu_cdb_value = 32'h100;
    step(); idle();
    checks++; if (alu_en !== 1'b0 || full !== 1'b1) begin
      errors++; $display("FAIL fill_woken got en=%0b full=%0b want 0/1", alu_en, full);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (alu_en !== 1'b1 || alu_rob_id !== 3'(i) || alu_op1 !== 32'h100 || alu_op2 !== 32'(i)) begin
        errors++; $display("FAIL drain_%0d got en=%0b rob=%0d op1=%0h op2=%0d want 1/%0d/100/%0d",
                           i, alu_en, alu_rob_id, alu_op1, alu_op2, i, i);
      end
      if (i == 0) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got %0b want 0", full); end
      end
    end
    step();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL drain_done got %0b want 0", alu_en); end
  endtask

  task automatic test_flush();
    insert(6'b0, 32'd3, 32'd4, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7, 32'd0);
    step();
    flush = 1'b1;
    insert(6'b0, 32'd8, 32'd9, 1'b0, 1'b0, 3'd0, 3'd0, 3'd6, 32'd0);
    step(); idle();
    checks++; if (alu_en !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL flush_kill got en=%0b full=%0b want 0/0", alu_en, full);
    end
    step();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL flush_dec_ignored got %0b want 0", alu_en); end
    for (int i = 0; i < 3; i++) begin
      insert(6'b0, 32'd0, 32'd0, 1'b1, 1'b0, 3'd5, 3'd0, 3'(i), 32'd0);
      step();
    end
    idle(); flush = 1'b1;
    step(); idle();
    checks++; if (alu_en !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL flush_pending got en=%0b full=%0b want 0/0", alu_en, full);
    end
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 3'd5; alu_cdb_value = 32'h55;
    step(); idle();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL flush_stale_%0d got %0b want 0", i, alu_en); end
    end
  endtask

  task automatic test_stall_and_reset();
    insert(6'b0, 32'd11, 32'd22, 1'b0, 1'b0, 3'd0, 3'd0, 3'd6, 32'd0);
    step(); idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL stall_%0d got %0b want 0", i, alu_en); end
    end
    rdy_in = 1'b1;
    insert(6'b0, 32'd1, 32'd2, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4, 32'd0);
    step(); idle();
    checks++; if (alu_en !== 1'b1 || alu_rob_id !== 3'd6 || alu_op1 !== 32'd11) begin
      errors++; $display("FAIL stall_release got en=%0b rob=%0d op1=%0d want 1/6/11", alu_en, alu_rob_id, alu_op1);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (alu_en !== 1'b0 || alu_rob_id !== 3'd0 || alu_op1 !== 32'd0) begin
      errors++; $display("FAIL async_reset got en=%0b rob=%0d op1=%0d want 0/0/0", alu_en, alu_rob_id, alu_op1);
    end
    step();
    rst_in = 1'b1;
    step();
    checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL reset_wiped got %0b want 0", alu_en); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_forward();
    test_fill_order();
    test_flush();
    test_stall_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
